conv_result_writer: RTL

Write-side counterpart of the convolution data mover. Accepts one row of PE_SIZE partial sums per handshake from the systolic array drain path and requantizes each to OUT_WIDTH. Packs the row into MEM2_DATA_WIDTH words and writes them sequentially into the output BRAM (mem2). Signals completion once MEM2_DEPTH words are written.

---
 rtl/conv_result_writer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/conv_result_writer.sv
// Requantizes PE_SIZE-wide partial-sum rows and streams them as packed words into mem2.
// Optional build macro CONV_WRITER_RELU_EN clamps negative partial sums to zero before requantization.
module conv_result_writer #(
    parameter int unsigned MEM2_DEPTH      = 896,
    parameter int unsigned MEM2_ADDR_WIDTH = 10,
    parameter int unsigned MEM2_DATA_WIDTH = 128,
    parameter int unsigned PE_SIZE         = 16,
    parameter int unsigned ACC_WIDTH       = 32,
    parameter int unsigned OUT_WIDTH       = 16,
    parameter int unsigned SHIFT           = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic [PE_SIZE*ACC_WIDTH-1:0]   psum_i,
    input  logic                           psum_valid_i,
    output logic                           psum_ready_o,
    output logic [MEM2_DATA_WIDTH-1:0]     mem2_d0,
    output logic [MEM2_ADDR_WIDTH-1:0]     mem2_addr0,
    output logic                           mem2_ce0,
    output logic                           mem2_we0,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int unsigned C             = MEM2_DATA_WIDTH / OUT_WIDTH;
    localparam int unsigned WORDS_PER_ROW = PE_SIZE / C;
    localparam int unsigned ROW_WIDTH     = PE_SIZE * OUT_WIDTH;
    localparam int unsigned WIDX_WIDTH    = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    localparam logic [WIDX_WIDTH-1:0]      LAST_WIDX = WIDX_WIDTH'(WORDS_PER_ROW - 1);
    localparam logic [MEM2_ADDR_WIDTH-1:0] LAST_ADDR = MEM2_ADDR_WIDTH'(MEM2_DEPTH - 1);
    localparam logic signed [ACC_WIDTH-1:0] Q_MAX    = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] Q_MIN    = ~Q_MAX;

    logic [1:0]                 state, state_n;
    logic [WIDX_WIDTH-1:0]      widx, widx_n;
    logic [MEM2_ADDR_WIDTH-1:0] addr, addr_n, next_addr;
    logic [ROW_WIDTH-1:0]       row_buf, row_buf_n, quant_row;
    logic [MEM2_DATA_WIDTH-1:0] d0_n;
    logic [MEM2_ADDR_WIDTH-1:0] addr0_n;
    logic                       ready_n, ce_n, busy_n, done_n;
    logic                       hs, load_row;

    function automatic logic [OUT_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH-1:0] a;
        logic signed [ACC_WIDTH-1:0] q;
        a = $signed(acc);
`ifdef CONV_WRITER_RELU_EN
        if (a[ACC_WIDTH-1]) a = '0;
`endif
        q = a >>> SHIFT;
        if (q > Q_MAX)      q = Q_MAX;
        else if (q < Q_MIN) q = Q_MIN;
        return q[OUT_WIDTH-1:0];
    endfunction

    function automatic logic [MEM2_DATA_WIDTH-1:0] word_of(input logic [ROW_WIDTH-1:0] row,
                                                          input logic [WIDX_WIDTH-1:0] k);
        return row[int'(k) * MEM2_DATA_WIDTH +: MEM2_DATA_WIDTH];
    endfunction

    // Requantized view of the incoming row; captured only on a handshake.
    always_comb begin
        quant_row = '0;
        for (int j = 0; j < PE_SIZE; j++) begin
            quant_row[j*OUT_WIDTH +: OUT_WIDTH] = requant(psum_i[j*ACC_WIDTH +: ACC_WIDTH]);
        end
    end

    assign hs        = psum_valid_i && psum_ready_o;
    assign next_addr = (addr == LAST_ADDR) ? '0 : addr + 1'b1;

    always_comb begin
        state_n   = state;
        widx_n    = widx;
        addr_n    = addr;
        row_buf_n = row_buf;
        d0_n      = mem2_d0;
        addr0_n   = mem2_addr0;
        ready_n   = 1'b0;
        ce_n      = 1'b0;
        done_n    = 1'b0;
        load_row  = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = LOAD;
                    addr_n  = '0;
                    ready_n = 1'b1;
                end
            end
            LOAD: begin
                if (hs) load_row = 1'b1;
                else    ready_n  = 1'b1;
            end
            WRITE: begin
                if (widx != LAST_WIDX) begin
                    widx_n  = WIDX_WIDTH'(widx + 1'b1);
                    d0_n    = word_of(row_buf, WIDX_WIDTH'(widx + 1'b1));
                    addr0_n = addr;
                    addr_n  = next_addr;
                    ce_n    = 1'b1;
                end else if (mem2_addr0 == LAST_ADDR) begin
                    state_n = IDLE;
                    addr0_n = '0;
                    done_n  = 1'b1;
                end else if (hs) begin
                    load_row = 1'b1;
                end else begin
                    state_n = LOAD;
                    ready_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Word 0 goes straight to the port so the first write lands the cycle after accept.
        if (load_row) begin
            state_n   = WRITE;
            row_buf_n = quant_row;
            widx_n    = '0;
            d0_n      = word_of(quant_row, '0);
            addr0_n   = addr;
            addr_n    = next_addr;
            ce_n      = 1'b1;
        end

        // Reopen for the next row while its last word is on the port, unless the frame ends there.
        if (ce_n && (widx_n == LAST_WIDX) && (addr0_n != LAST_ADDR)) ready_n = 1'b1;

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            widx         <= '0;
            addr         <= '0;
            row_buf      <= '0;
            psum_ready_o <= 1'b0;
            mem2_d0      <= '0;
            mem2_addr0   <= '0;
            mem2_ce0     <= 1'b0;
            mem2_we0     <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state        <= state_n;
            widx         <= widx_n;
            addr         <= addr_n;
            row_buf      <= row_buf_n;
            psum_ready_o <= ready_n;
            mem2_d0      <= d0_n;
            mem2_addr0   <= addr0_n;
            mem2_ce0     <= ce_n;
            mem2_we0     <= ce_n;
            busy_o       <= busy_n;
            done_o       <= done_n;
        end
    end

endmodule
